// File: rtl/shift_deser_rx_pkg.sv
// Shared types and constants for the serial deserializer.
// Holds FSM states, shift-core ops, frame bit levels and WIDTH default.
package shift_deser_rx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    SH_HOLD,
    SH_LEFT,
    SH_RIGHT,
    SH_CLR
  } shift_op_t;

endpackage

// File: rtl/shift_deser_rx_if.sv
// Output word bus of the deserializer: dout/dout_valid with out_ready.
// master = word producer, slave = word consumer.
interface shift_deser_rx_if
  import shift_deser_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             out_ready;

  modport master (
    output dout,
    output dout_valid,
    input  out_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output out_ready
  );

endinterface

// File: rtl/shift_deser_rx_shift_core.sv
// Bidirectional shift register: hold, shift left, shift right, clear.
// Ports: clk, clr_n, op_i (shift_op_t), din_i serial in, q_o contents.
module shift_core
  import shift_deser_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  shift_op_t        op_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (op_i)
      SH_HOLD:  q_d = q_q;
      SH_LEFT:  q_d = {q_q[WIDTH-2:0], din_i};
      SH_RIGHT: q_d = {din_i, q_q[WIDTH-1:1]};
      SH_CLR:   q_d = '0;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_deser_rx.sv
// Serial frame receiver: start 0, WIDTH data bits, stop 1, per strobe.
// Ports: clk, clr_n, sdin, sdin_en, lsb_first, busy, frame_err, overrun, out_if.
module shift_deser_rx
  import shift_deser_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sdin,
  input  logic             sdin_en,
  input  logic             lsb_first,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  shift_deser_rx_if.master out_if
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  shift_op_t        op;
  logic [WIDTH-1:0] sh;
  logic             hs;

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .clr_n (clr_n),
    .op_i  (op),
    .din_i (sdin),
    .q_o   (sh)
  );

  assign hs = valid_q & out_if.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
    dout_d  = dout_q;
    valid_d = valid_q & ~hs;
    ovr_d   = ovr_q & ~hs;
    ferr_d  = 1'b0;
    op      = SH_HOLD;
    if (sdin_en) begin
      unique case (state_q)
        IDLE: begin
          if (sdin == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
            lsb_d   = lsb_first;
            op      = SH_CLR;
          end
        end
        DATA: begin
          op    = lsb_q ? SH_RIGHT : SH_LEFT;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (sdin == STOP_BIT) begin
            // A same-cycle handshake frees the register for the new word.
            if (!valid_q || hs) begin
              dout_d  = sh;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign frame_err         = ferr_q;
  assign overrun           = ovr_q;
  assign out_if.dout       = dout_q;
  assign out_if.dout_valid = valid_q;

endmodule

// File: tb/tb_shift_deser_rx.sv
// Self-checking bench for shift_deser_rx (WIDTH=8).
// Frame-level reference model plus directed and random frames.
module tb_shift_deser_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic sdin = 1'b1;
  logic sdin_en = 1'b0;
  logic lsb_first = 1'b1;
  logic busy, frame_err, overrun;

  shift_deser_rx_if #(.WIDTH(W)) bus ();

  shift_deser_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .sdin      (sdin),
    .sdin_en   (sdin_en),
    .lsb_first (lsb_first),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .out_if    (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_mode = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks a frame as a list of received bits.
  bit         m_active = 1'b0;
  bit         m_lsb = 1'b0;
  bit         bq[$];
  logic [W-1:0] exp_dout = '0;
  bit         exp_valid = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         exp_ovr = 1'b0;

  function automatic logic [W-1:0] assemble(input bit lsb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) w[i] = bq[i];
      else     w[W-1-i] = bq[i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_active  = 1'b0;
      bq.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      bit hs;
      bit nv, no, nf;
      logic [W-1:0] nd;
      hs = exp_valid && bus.out_ready;
      nv = exp_valid && !hs;
      no = exp_ovr && !hs;
      nf = 1'b0;
      nd = exp_dout;
      if (sdin_en) begin
        if (!m_active) begin
          if (sdin == 1'b0) begin
            m_active = 1'b1;
            m_lsb = lsb_first;
            bq.delete();
          end
        end else if (bq.size() < W) begin
          bq.push_back(sdin);
        end else begin
          m_active = 1'b0;
          if (sdin == 1'b1) begin
            if (!exp_valid || hs) begin
              nd = assemble(m_lsb);
              nv = 1'b1;
            end else begin
              no = 1'b1;
            end
          end else begin
            nf = 1'b1;
          end
        end
      end
      exp_dout  = nd;
      exp_valid = nv;
      exp_ovr   = no;
      exp_ferr  = nf;
    end
  end

  always @(negedge clk) begin
    chk("dout", bus.dout, exp_dout);
    chk("dout_valid", bus.dout_valid, exp_valid);
    chk("busy", busy, m_active);
    chk("frame_err", frame_err, exp_ferr);
    chk("overrun", overrun, exp_ovr);
  end

  always @(negedge clk)
    if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));

  task automatic strobe(input logic b, input bit rdy);
    int gap;
    gap = rnd_mode ? int'($urandom_range(0, 3)) : 3;
    repeat (gap) @(negedge clk);
    sdin = b;
    sdin_en = 1'b1;
    if (rdy) bus.out_ready = 1'b1;
    if (rnd_mode && $urandom_range(0, 3) == 0) lsb_first = ~lsb_first;
    @(negedge clk);
    sdin_en = 1'b0;
    sdin = 1'b1;
    if (rdy) bus.out_ready = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] w, input bit lsb,
                      input logic stop, input int tog, input bit rdy);
    lsb_first = lsb;
    strobe(1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      if (i == tog) lsb_first = ~lsb_first;
      strobe(lsb ? w[i] : w[W-1-i], 1'b0);
    end
    strobe(stop, rdy);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_valid", bus.dout_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    bus.out_ready = 1'b1;
    send(8'hA5, 1'b1, 1'b1, -1, 1'b0);
    chk("lsb_dout", bus.dout, 8'hA5);
    chk("lsb_valid", bus.dout_valid, 1'b1);
    chk("model_a5", exp_dout, 8'hA5);

    send(8'hA5, 1'b0, 1'b1, -1, 1'b0);
    chk("msb_dout", bus.dout, 8'hA5);
    send(8'hA5, 1'b0, 1'b1, 3, 1'b0);
    chk("msb_tog_dout", bus.dout, 8'hA5);
    chk("msb_tog_valid", bus.dout_valid, 1'b1);

    @(negedge clk);
    bus.out_ready = 1'b0;
    send(8'h3C, 1'b1, 1'b1, -1, 1'b0);
    send(8'h81, 1'b1, 1'b1, -1, 1'b0);
    chk("bp_dout", bus.dout, 8'h3C);
    chk("bp_ovr", overrun, 1'b1);
    chk("model_ovr", exp_ovr, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_valid_clr", bus.dout_valid, 1'b0);
    chk("bp_ovr_clr", overrun, 1'b0);
    chk("bp_dout_hold", bus.dout, 8'h3C);

    send(8'h55, 1'b1, 1'b0, -1, 1'b0);
    chk("fe_pulse", frame_err, 1'b1);
    chk("fe_valid", bus.dout_valid, 1'b0);
    @(negedge clk);
    chk("fe_end", frame_err, 1'b0);
    send(8'h0F, 1'b1, 1'b1, -1, 1'b0);
    chk("fe_next", bus.dout, 8'h0F);
    chk("model_0f", exp_dout, 8'h0F);

    lsb_first = 1'b1;
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_dout", bus.dout, 8'h00);
    chk("arst_valid", bus.dout_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ferr", frame_err, 1'b0);
    chk("arst_ovr", overrun, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    send(8'hF0, 1'b1, 1'b1, -1, 1'b0);
    chk("post_rst", bus.dout, 8'hF0);

    send(8'h99, 1'b0, 1'b1, -1, 1'b1);
    chk("sim_dout", bus.dout, 8'h99);
    chk("sim_valid", bus.dout_valid, 1'b1);
    chk("sim_ovr", overrun, 1'b0);

    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0), -1, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    rnd_mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_deser_rx.md
SHIFT_DESER_RX -- requirements
Module: shift_deser_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per frame (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port sdin, input, 1 bit, serial line; idles high.
REQ-005 The block SHALL have port sdin_en, input, 1 bit, bit strobe; sdin is sampled only on cycles where sdin_en=1.
REQ-006 The block SHALL have port lsb_first, input, 1 bit, bit order: 1 means the first data bit is dout[0]; 0 means the first data bit is dout[WIDTH-1].
REQ-007 The block SHALL have port dout, output, WIDTH bits, received word.
REQ-008 The block SHALL have port dout_valid, output, 1 bit, dout holds an unconsumed word.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer accepts dout when dout_valid=1 and out_ready=1 in the same cycle.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is in progress (state not IDLE).
REQ-011 The block SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-012 The block SHALL have port overrun, output, 1 bit, sticky flag for a word lost to a full output register.

Function
REQ-013 Frame format SHALL be: start bit 0, then WIDTH data bits, then stop bit 1, each on one sdin_en strobe.
REQ-014 FSM states SHALL be IDLE, DATA and STOP.
REQ-015 IDLE SHALL go to DATA on a strobe with sdin=0; in the same cycle the bit counter clears and lsb_first is latched for the frame.
REQ-016 Changes to lsb_first mid-frame SHALL have no effect until the next start bit.
REQ-017 In DATA, each strobe SHALL shift sdin into the shift register:
 - LSB-first: shift right, insert at bit WIDTH-1.
 - MSB-first: shift left, insert at bit 0.
REQ-018 DATA SHALL go to STOP on the strobe carrying data bit WIDTH-1; the counter width is clog2(WIDTH) bits.
REQ-019 In STOP with sdin=1, the block SHALL return to IDLE and deliver the word:
 - dout_valid=0, or dout_valid=1 with out_ready=1 this cycle: dout loads the shift register and dout_valid=1 next cycle.
 - otherwise: the word is dropped, dout is unchanged and overrun is set.
REQ-020 In STOP with sdin=0, the block SHALL drop the word, pulse frame_err for one cycle and return to IDLE; dout and dout_valid are unaffected.
REQ-021 The block SHALL make data visible on dout one clk after the stop strobe.
REQ-022 When a handshake (dout_valid & out_ready) occurs with no new word arriving, dout_valid SHALL clear next cycle and dout SHALL hold its value.
REQ-023 When a handshake and a stop-bit delivery occur in the same cycle, the new word SHALL load and dout_valid SHALL stay 1, with no overrun.
REQ-024 overrun SHALL clear only on a handshake or on reset; when a set and a clear occur in the same cycle, set wins.
REQ-025 Cycles with sdin_en=0 SHALL leave all state unchanged, except handshake effects on dout_valid and overrun.
REQ-026 A strobe in IDLE with sdin=1 SHALL be ignored.

Reset
REQ-027 While clr_n=0, the block SHALL asynchronously force:
 - state to IDLE; counter, shift register and dout to 0;
 - dout_valid, busy, frame_err and overrun to 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no frame_err; the next frame requires a fresh start bit.
REQ-029 Reset release SHALL be treated as asynchronous to clk; no output other than those in REQ-027 depends on reset.

Structure
REQ-030 A shared package SHALL hold:
 - the state enumeration (IDLE/DATA/STOP);
 - localparams START_BIT=0 and STOP_BIT=1;
 - the default WIDTH.
REQ-031 The bidirectional shift register (hold, shift left, shift right, clear) SHALL be one sub-module, shift_core; the FSM, counter and output register stay in the top level.

Verification
REQ-032 Scenario LSB-first: WIDTH=8, strobe every 4th clk, send 0,1,0,1,0,0,1,0,1,1 -> dout=0xA5 and dout_valid=1 one clk after the stop strobe.
REQ-033 Scenario MSB-first: same bit stream with lsb_first=0 -> dout=0xA5; toggling lsb_first mid-frame still yields 0xA5.
REQ-034 Scenario back-pressure: out_ready=0, send 0x3C then 0x81 -> dout stays 0x3C and overrun=1; raise out_ready for 1 clk -> dout_valid=0 and overrun=0.
REQ-035 Scenario frame error: send 0x55 with stop bit 0 -> frame_err pulses exactly 1 clk and dout_valid is unchanged; the next good frame 0x0F is received correctly.
REQ-036 Scenario reset: clr_n low after 4 data bits -> all outputs 0 immediately (asynchronous, before the next clk edge); then a full frame 0xF0 -> dout=0xF0.
REQ-037 Scenario simultaneous events: handshake on the same clk as the stop strobe of 0x99 -> dout=0x99, dout_valid stays 1 and overrun=0.
